// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-master I2C byte engine; START/WRITE/READ/STOP on a quarter-bit timebase with stretching and arbitration.
module i2c_master_ctrl #(
  parameter int DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       ack,
  output logic       arb_lost,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACKBIT, STOP} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [1:0] q;
  logic [2:0] idx, op;
  logic [7:0] d, rx;
  logic scl_r, sda_r, hold, qend, samp, last, lost, acc, rdone;
  assign cmd_ready = state == IDLE;
  assign acc = cmd_valid && cmd_ready;
  // Lines hold their last driven level while idle so a repeated START begins with SCL still low.
  always_comb begin
    scl_oe = scl_r;
    sda_oe = sda_r;
    nxt = state;
    case (state)
      START: begin
        scl_oe = q == 2'd0 ? scl_r : q == 2'd3;
        sda_oe = q[1];
      end
      BIT, ACKBIT: begin
        scl_oe = q == 2'd0 || q == 2'd3;
        sda_oe = state == BIT ? op == 3'd1 && !d[~idx] : op == 3'd2;
      end
      STOP: begin
        scl_oe = q == 2'd0;
        sda_oe = !q[1];
      end
      default: ;
    endcase
    hold = !scl_oe && !scl_i;
    qend = state != IDLE && cnt == 16'(DIV - 1) && !hold;
    samp = qend && q == 2'd2;
    last = qend && q == 2'd3;
    lost = state == BIT && op == 3'd1 && samp && !sda_oe && !sda_i;
    rdone = last && state == ACKBIT && op != 3'd1;
    case (state)
      IDLE: begin
        if (acc && cmd == 3'd0) nxt = START;
        else if (acc && cmd == 3'd4) nxt = STOP;
        else if (acc && cmd <= 3'd3) nxt = BIT;
      end
      START, STOP, ACKBIT: if (last) nxt = IDLE;
      BIT: begin
        if (lost) nxt = IDLE;
        else if (last && idx == 3'd7) nxt = ACKBIT;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      idx <= '0;
      op <= '0;
      d <= '0;
      rx <= '0;
      scl_r <= 1'b0;
      sda_r <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      done <= 1'b0;
      ack <= 1'b0;
      arb_lost <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      scl_r <= scl_oe && !lost;
      sda_r <= sda_oe && !lost;
      done <= (acc && cmd > 3'd4) || lost || (last && state != BIT);
      rd_valid <= rdone;
      cnt <= state == IDLE || qend ? '0 : hold ? cnt : cnt + 16'd1;
      q <= state == IDLE ? '0 : qend ? q + 2'd1 : q;
      idx <= state == IDLE ? '0 : last && state == BIT ? idx + 3'd1 : idx;
      if (samp && state == BIT) rx <= {rx[6:0], sda_i};
      if (samp && state == ACKBIT && op == 3'd1) ack <= !sda_i;
      if (rdone) rd_data <= rx;
      if (acc) begin
        op <= cmd;
        d <= wr_data;
      end
      if (acc && cmd == 3'd0) arb_lost <= 1'b0;
      else if (lost) arb_lost <= 1'b1;
      if (lost || (last && state == STOP)) busy <= 1'b0;
      else if (last && state == START) busy <= 1'b1;
    end
  end
endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 125, meaning clk cycles per SCL quarter-bit; legal range 2..65535 (100 kHz SCL at 50 MHz).
REQ-002 clk  input  1  the single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accept strobe qualifier.
REQ-006 cmd  input  3  0=START, 1=WRITE, 2=READ_ACK, 3=READ_NACK, 4=STOP, 5-7 reserved.
REQ-007 wr_data  input  8  byte for WRITE.
REQ-008 rd_data  output  8  last byte read.
REQ-009 rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-010 done  output  1  one-cycle pulse, command finished.
REQ-011 ack  output  1  1 = target pulled SDA low in last WRITE ack slot.
REQ-012 arb_lost  output  1  sticky arbitration-loss flag.
REQ-013 busy  output  1  high between START completion and STOP completion.
REQ-014 scl_i, sda_i  input  1 each  sampled bus levels.
REQ-015 scl_oe, sda_oe  output  1 each  1 = pull line low, 0 = release.

Function
REQ-016 Accept SHALL occur on a cycle with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE and SHALL fall the cycle after accept; cmd and wr_data SHALL be captured at accept.
REQ-017 States SHALL be IDLE, START, BIT, ACKBIT, STOP; each bus command is a sequence of quarters Q0-Q3 of DIV cycles each.
REQ-018 START: Q0 sda_oe=0 (scl_oe unchanged); Q1 scl_oe=0; Q2 sda_oe=1; Q3 scl_oe=1; supports repeated START.
REQ-019 Data bit: Q0 scl_oe=1 with sda_oe set; Q1-Q2 scl_oe=0; sda_i sampled on last cycle of Q2; Q3 scl_oe=1.
REQ-020 WRITE: 8 bits MSB first with sda_oe=~bit, then ACKBIT with sda_oe=0; ack=~sampled sda_i.
REQ-021 READ_ACK/READ_NACK: 8 bits with sda_oe=0, shifted MSB first; ACKBIT drives sda_oe=1 (READ_ACK) or 0 (READ_NACK); rd_data updated and rd_valid pulsed in the done cycle.
REQ-022 STOP: Q0 scl_oe=1, sda_oe=1; Q1 scl_oe=0; Q2 sda_oe=0; Q3 both released; busy falls with done.
REQ-023 Clock stretching: in any quarter with scl_oe=0, the quarter counter SHALL hold while scl_i=0.
REQ-024 Without stretching, done SHALL assert exactly 4*DIV+1 cycles after accept for START/STOP and 36*DIV+1 for WRITE/READ; cmd_ready SHALL rise in the done cycle.
REQ-025 Arbitration: during WRITE data bits, sda_oe=0 and sampled sda_i=0 SHALL set arb_lost, release both lines the next cycle, pulse done, return IDLE, clear busy; arb_lost SHALL clear on the next accepted START.
REQ-026 Reserved cmd codes SHALL be accepted, produce no bus activity and pulse done 1 cycle after accept.
REQ-027 cmd_valid while not ready SHALL be ignored; no queuing.

Reset
REQ-028 rst=1 SHALL on the next edge force IDLE, scl_oe=0, sda_oe=0, cmd_ready=1, rd_data=0x00, rd_valid=0, done=0, ack=0, arb_lost=0, busy=0, including mid-command; no done is issued for the aborted command.

Verification
REQ-029 DIV=4, START then STOP, bus pulled high -> sda falls 4 cycles before scl; done at accept+17 for each; busy 1 then 0.
REQ-030 WRITE 0xA5, model ACKs -> SDA pattern 1,0,1,0,0,1,0,1 sampled on SCL high, ack=1, done at accept+145.
REQ-031 READ_NACK, model drives 0x3C -> rd_data=0x3C, rd_valid with done, sda_oe=0 during ACKBIT.
REQ-032 Model holds scl_i low 10 extra cycles in bit 3 of WRITE -> done delayed exactly 10 cycles, data intact.
REQ-033 WRITE 0xFF, model forces sda_i=0 in bit 2 -> arb_lost=1, scl_oe=sda_oe=0 next cycle, done pulse; next START clears arb_lost.
REQ-034 rst asserted mid-READ -> all outputs at reset values next edge, no done/rd_valid.
